// File: rtl/tlc_controller_if.sv
// tlc_controller_if: bundles the timer handshake, request inputs and light outputs.
// Latency: none, wires only.
// Backpressure: none; master is the light controller, slave is the surrounding logic.
interface tlc_controller_if #(
  parameter int N = 13
) ();

  logic         timer_done;
  logic [N-1:0] final_value;
  logic         sensor;
  logic         ped_req;
  logic [2:0]   main_light;
  logic [2:0]   side_light;
  logic         walk;

  modport master (
    input  timer_done,
    input  sensor,
    input  ped_req,
    output final_value,
    output main_light,
    output side_light,
    output walk
  );

  modport slave (
    output timer_done,
    output sensor,
    output ped_req,
    input  final_value,
    input  main_light,
    input  side_light,
    input  walk
  );

endinterface

// File: rtl/tlc_controller.sv
// tlc_controller: main/side road light sequencer that programs an external interval timer.
// Latency: lights and final_value decode from the state register; state moves on edges with timer_done=1.
// Backpressure: none; sensor/ped_req are latched into pending flags until their phase is served.
// Optional pedestrian walk phase is compiled in when macro TLC_PED_EN is defined.
module tlc_controller #(
  parameter int N        = 13,
  parameter int GREEN_T  = 8,
  parameter int SIDE_T   = 5,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int PED_T    = 4
) (
  input logic              clk,
  input logic              reset_n,
  tlc_controller_if.master bus
);

  // Timer terminal counts: an interval of D cycles is programmed as D-1.
  localparam logic [N-1:0] GREEN_FV  = N'(GREEN_T - 1);
  localparam logic [N-1:0] SIDE_FV   = N'(SIDE_T - 1);
  localparam logic [N-1:0] YELLOW_FV = N'(YELLOW_T - 1);
  localparam logic [N-1:0] ALLRED_FV = N'(ALLRED_T - 1);
  localparam logic [N-1:0] PED_FV    = N'(PED_T - 1);

  // Light encodings, {red, yellow, green}.
  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_YELLOW = 3'b010;
  localparam logic [2:0] LT_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    ALL_R1   = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_Y   = 3'd4,
`ifdef TLC_PED_EN
    ALL_R2   = 3'd5,
    PED_WALK = 3'd6
`else
    ALL_R2   = 3'd5
`endif
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         side_pend;
  logic         ped_pend;
  logic         enter_side;
  logic [N-1:0] final_value_c;
  logic [2:0]   main_c;
  logic [2:0]   side_c;
  logic         walk_c;

  // State register; reset abandons whatever interval was in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MAIN_G;
    end else begin
      state <= state_nxt;
    end
  end

  // A side request is consumed on the edge that enters SIDE_G; that consumption wins over a new request.
  assign enter_side = (state_nxt == SIDE_G) && (state != SIDE_G);

  // Side-road request latch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      side_pend <= 1'b0;
    end else if (enter_side) begin
      side_pend <= 1'b0;
    end else if (bus.sensor) begin
      side_pend <= 1'b1;
    end
  end

`ifdef TLC_PED_EN
  logic enter_ped;

  assign enter_ped = (state_nxt == PED_WALK) && (state != PED_WALK);

  // Pedestrian request latch, consumed on the edge that enters PED_WALK.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pend <= 1'b0;
    end else if (enter_ped) begin
      ped_pend <= 1'b0;
    end else if (bus.ped_req) begin
      ped_pend <= 1'b1;
    end
  end
`else
  // Without the walk phase the button is ignored and no pedestrian request is ever pending.
  logic unused_ped;

  assign ped_pend   = 1'b0;
  assign unused_ped = ^{bus.ped_req, PED_FV};
`endif

  // Next-state and Moore output decode; outputs depend on the state register only.
  always_comb begin
    state_nxt     = state;
    final_value_c = GREEN_FV;
    main_c        = LT_RED;
    side_c        = LT_RED;
    walk_c        = 1'b0;
    case (state)
      MAIN_G: begin
        main_c        = LT_GREEN;
        final_value_c = GREEN_FV;
        // With nothing waiting the main road simply re-arms another full green interval.
        if (bus.timer_done && (side_pend || ped_pend)) begin
          state_nxt = MAIN_Y;
        end
      end
      MAIN_Y: begin
        main_c        = LT_YELLOW;
        final_value_c = YELLOW_FV;
        if (bus.timer_done) begin
          state_nxt = ALL_R1;
        end
      end
      ALL_R1: begin
        final_value_c = ALLRED_FV;
        if (bus.timer_done) begin
`ifdef TLC_PED_EN
          state_nxt = side_pend ? SIDE_G : PED_WALK;
`else
          // Only a side request can have ended main green, but recover to MAIN_G if none is seen.
          state_nxt = side_pend ? SIDE_G : MAIN_G;
`endif
        end
      end
      SIDE_G: begin
        side_c        = LT_GREEN;
        final_value_c = SIDE_FV;
        if (bus.timer_done) begin
          state_nxt = SIDE_Y;
        end
      end
      SIDE_Y: begin
        side_c        = LT_YELLOW;
        final_value_c = YELLOW_FV;
        if (bus.timer_done) begin
          state_nxt = ALL_R2;
        end
      end
      ALL_R2: begin
        final_value_c = ALLRED_FV;
        if (bus.timer_done) begin
`ifdef TLC_PED_EN
          state_nxt = ped_pend ? PED_WALK : MAIN_G;
`else
          state_nxt = MAIN_G;
`endif
        end
      end
`ifdef TLC_PED_EN
      PED_WALK: begin
        walk_c        = 1'b1;
        final_value_c = PED_FV;
        if (bus.timer_done) begin
          state_nxt = MAIN_G;
        end
      end
`endif
      default: begin
        // Illegal encoding: both roads red and recover to MAIN_G without waiting for the timer.
        state_nxt = MAIN_G;
      end
    endcase
  end

  assign bus.final_value = final_value_c;
  assign bus.main_light  = main_c;
  assign bus.side_light  = side_c;
  assign bus.walk        = walk_c;

endmodule

// File: tb/tb_tlc_controller.sv
// tb_tlc_controller: directed checks of the light sequencer against hand-written phase tables.
// Two instances: default timings, and a short-timing build exercising 1-cycle intervals.
// A simple up-counting interval timer model closes the timer_done/final_value loop for each.
module tb_tlc_controller;

  localparam int N    = 13;
  localparam int P_MG = 0;
  localparam int P_MY = 1;
  localparam int P_AR = 2;
  localparam int P_SG = 3;
  localparam int P_SY = 4;
  localparam int P_PW = 5;

  logic         clk;
  logic         reset_n;
  bit           sel;
  int           n_chk  = 0;
  int           n_pass = 0;
  logic [N-1:0] cnt0;
  logic [N-1:0] cnt1;

  tlc_controller_if #(.N(N)) bus0 ();
  tlc_controller_if #(.N(N)) bus1 ();

  tlc_controller #(.N(N)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  tlc_controller #(
    .N(N), .GREEN_T(2), .SIDE_T(1), .YELLOW_T(1), .ALLRED_T(1), .PED_T(1)
  ) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interval timer model: counts 0..final_value, pulses done on the terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt0 <= '0;
    else if (cnt0 == bus0.final_value) cnt0 <= '0;
    else cnt0 <= cnt0 + 1'b1;
  end
  assign bus0.timer_done = (cnt0 == bus0.final_value);

  // Same timer model for the short-timing instance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt1 <= '0;
    else if (cnt1 == bus1.final_value) cnt1 <= '0;
    else cnt1 <= cnt1 + 1'b1;
  end
  assign bus1.timer_done = (cnt1 == bus1.final_value);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic set_in(input logic s, input logic p);
    bus0.sensor  = sel ? 1'b0 : s;
    bus0.ped_req = sel ? 1'b0 : p;
    bus1.sensor  = sel ? s : 1'b0;
    bus1.ped_req = sel ? p : 1'b0;
  endtask

  function automatic logic [2:0] exp_main(input int code);
    case (code)
      P_MG:    return 3'b001;
      P_MY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_side(input int code);
    case (code)
      P_SG:    return 3'b001;
      P_SY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic chk_out(input string tag, input int code, input int fv);
    chk({tag, ".main"}, sel ? 32'(bus1.main_light) : 32'(bus0.main_light), 32'(exp_main(code)));
    chk({tag, ".side"}, sel ? 32'(bus1.side_light) : 32'(bus0.side_light), 32'(exp_side(code)));
    chk({tag, ".walk"}, sel ? 32'(bus1.walk) : 32'(bus0.walk), (code == P_PW) ? 32'd1 : 32'd0);
    chk({tag, ".fv"}, sel ? 32'(bus1.final_value) : 32'(bus0.final_value), 32'(fv));
  endtask

  // Run cyc cycles of a phase lasting dur cycles, optionally pulsing/holding requests.
  task automatic run_phase(input int code, input int dur, input int cyc, input int s_at,
                           input int p_at, input bit s_hold, input string tag);
    for (int i = 0; i < cyc; i++) begin
      set_in(s_hold || (i == s_at), i == p_at);
      chk_out(tag, code, dur - 1);
      chk({tag, ".done"}, sel ? 32'(bus1.timer_done) : 32'(bus0.timer_done),
          (i == dur - 1) ? 32'd1 : 32'd0);
      tick();
    end
    set_in(1'b0, 1'b0);
  endtask

  // Assert reset mid-cycle, check outputs at once and while held, release just after an edge.
  task automatic do_reset(input int green_len, input string tag);
    reset_n = 1'b0;
    set_in(1'b0, 1'b0);
    #1;
    chk_out({tag, ".now"}, P_MG, green_len - 1);
    tick();
    tick();
    chk_out({tag, ".held"}, P_MG, green_len - 1);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    sel     = 1'b0;
    set_in(1'b0, 1'b0);
    #2;

    // Idle: 100 cycles of main green, timer_done every 8th cycle.
    do_reset(8, "rst0");
    for (int k = 0; k < 13; k++) begin
      run_phase(P_MG, 8, (k == 12) ? 4 : 8, -1, -1, 1'b0, "idle");
    end

    // Single sensor pulse at cycle 3.
    do_reset(8, "rst1");
    run_phase(P_MG, 8, 8, 3, -1, 1'b0, "sens.mg");
    run_phase(P_MY, 3, 3, -1, -1, 1'b0, "sens.my");
    run_phase(P_AR, 2, 2, -1, -1, 1'b0, "sens.ar1");
    run_phase(P_SG, 5, 5, -1, -1, 1'b0, "sens.sg");
    run_phase(P_SY, 3, 3, -1, -1, 1'b0, "sens.sy");
    run_phase(P_AR, 2, 2, -1, -1, 1'b0, "sens.ar2");
    run_phase(P_MG, 8, 8, -1, -1, 1'b0, "sens.mg2");

    // Pedestrian button only.
    do_reset(8, "rst2");
`ifdef TLC_PED_EN
    run_phase(P_MG, 8, 8, -1, 3, 1'b0, "ped.mg");
    run_phase(P_MY, 3, 3, -1, -1, 1'b0, "ped.my");
    run_phase(P_AR, 2, 2, -1, -1, 1'b0, "ped.ar1");
    run_phase(P_PW, 4, 4, -1, -1, 1'b0, "ped.pw");
    run_phase(P_MG, 8, 8, -1, -1, 1'b0, "ped.mg2");
`else
    run_phase(P_MG, 8, 8, -1, 3, 1'b0, "pedoff.mg");
    run_phase(P_MG, 8, 8, -1, -1, 1'b0, "pedoff.mg2");
`endif

    // Sensor and button together during main green: side road served first.
    do_reset(8, "rst3");
    run_phase(P_MG, 8, 8, 2, 2, 1'b0, "both.mg");
    run_phase(P_MY, 3, 3, -1, -1, 1'b0, "both.my");
    run_phase(P_AR, 2, 2, -1, -1, 1'b0, "both.ar1");
    run_phase(P_SG, 5, 5, -1, -1, 1'b0, "both.sg");
    run_phase(P_SY, 3, 3, -1, -1, 1'b0, "both.sy");
    run_phase(P_AR, 2, 2, -1, -1, 1'b0, "both.ar2");
`ifdef TLC_PED_EN
    run_phase(P_PW, 4, 4, -1, -1, 1'b0, "both.pw");
`endif
    run_phase(P_MG, 8, 8, -1, -1, 1'b0, "both.mg2");
    run_phase(P_MG, 8, 8, -1, -1, 1'b0, "both.mg3");

    // Sensor held through side green re-arms the request: one main green interval only.
    do_reset(8, "rst4");
    run_phase(P_MG, 8, 8, 3, -1, 1'b0, "hold.mg");
    run_phase(P_MY, 3, 3, -1, -1, 1'b0, "hold.my");
    run_phase(P_AR, 2, 2, -1, -1, 1'b0, "hold.ar1");
    run_phase(P_SG, 5, 5, -1, -1, 1'b1, "hold.sg");
    run_phase(P_SY, 3, 3, -1, -1, 1'b0, "hold.sy");
    run_phase(P_AR, 2, 2, -1, -1, 1'b0, "hold.ar2");
    run_phase(P_MG, 8, 8, -1, -1, 1'b0, "hold.mg2");
    run_phase(P_MY, 3, 3, -1, -1, 1'b0, "hold.my2");
    run_phase(P_AR, 2, 2, -1, -1, 1'b0, "hold.ar3");
    run_phase(P_SG, 5, 5, -1, -1, 1'b0, "hold.sg2");

    // Sensor only on the SIDE_G entry edge: the clear wins, main green repeats.
    do_reset(8, "rst5");
    run_phase(P_MG, 8, 8, 3, -1, 1'b0, "clr.mg");
    run_phase(P_MY, 3, 3, -1, -1, 1'b0, "clr.my");
    run_phase(P_AR, 2, 2, 1, -1, 1'b0, "clr.ar1");
    run_phase(P_SG, 5, 5, -1, -1, 1'b0, "clr.sg");
    run_phase(P_SY, 3, 3, -1, -1, 1'b0, "clr.sy");
    run_phase(P_AR, 2, 2, -1, -1, 1'b0, "clr.ar2");
    run_phase(P_MG, 8, 8, -1, -1, 1'b0, "clr.mg2");
    run_phase(P_MG, 8, 8, -1, -1, 1'b0, "clr.mg3");

    // Reset in the middle of side green, then a full 8-cycle main green.
    do_reset(8, "rst6");
    run_phase(P_MG, 8, 8, 3, -1, 1'b0, "mid.mg");
    run_phase(P_MY, 3, 3, -1, -1, 1'b0, "mid.my");
    run_phase(P_AR, 2, 2, -1, -1, 1'b0, "mid.ar1");
    run_phase(P_SG, 5, 2, -1, -1, 1'b0, "mid.sg");
    do_reset(8, "midrst");
    run_phase(P_MG, 8, 8, -1, -1, 1'b0, "mid.mg2");

    // Short-timing instance: 1-cycle yellow, all-red and side green.
    sel = 1'b1;
    do_reset(2, "rst7");
    run_phase(P_MG, 2, 2, 0, -1, 1'b0, "short.mg");
    run_phase(P_MY, 1, 1, -1, -1, 1'b0, "short.my");
    run_phase(P_AR, 1, 1, -1, -1, 1'b0, "short.ar1");
    run_phase(P_SG, 1, 1, -1, -1, 1'b0, "short.sg");
    run_phase(P_SY, 1, 1, -1, -1, 1'b0, "short.sy");
    run_phase(P_AR, 1, 1, -1, -1, 1'b0, "short.ar2");
    run_phase(P_MG, 2, 2, -1, -1, 1'b0, "short.mg2");
    run_phase(P_MG, 2, 2, -1, -1, 1'b0, "short.mg3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
